// File: rtl/tick_pkg.sv
// Shared definitions for the tick scheduler.
//  - state_t    : FSM encodings (IDLE=00, RUN=01, PAUSE=10), also driven on the state port
//  - LVL_W      : width of the speed level, sized for the level saturation value
//  - PER_W      : width of the game period down-counter
//  - period_calc: level/slow -> effective game period, clamped to the floor
package tick_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10
  } state_t;

  localparam int MAX_LEVEL_CFG = 7;
  localparam int LVL_W         = $clog2(MAX_LEVEL_CFG + 1);
  localparam int PER_W         = 26;
  // One spare bit so that base - level*step can go negative and be caught.
  localparam int CALC_W        = PER_W + 1;

  // eff = max(base - lvl*step, min_p), doubled in slow mode.
  // A negative difference is below any positive floor, so one signed compare clamps both cases.
  function automatic logic [PER_W-1:0] period_calc(
    input logic [CALC_W-1:0] base,
    input logic [CALC_W-1:0] step,
    input logic [CALC_W-1:0] min_p,
    input logic [LVL_W-1:0]  lvl,
    input logic              slow
  );
    logic signed [CALC_W-1:0] diff;
    logic signed [CALC_W-1:0] floor_v;
    logic        [CALC_W-1:0] clamped;
    diff    = signed'(base - (CALC_W'(lvl) * step));
    floor_v = signed'(min_p);
    clamped = (diff < floor_v) ? min_p : unsigned'(diff);
    return slow ? PER_W'(clamped << 1) : PER_W'(clamped);
  endfunction

endpackage

// File: rtl/tick_period_calc.sv
// Combinational game-period calculator.
// Ports:
//  level  in   LVL_W  speed level the period is computed for
//  slow   in   1      1 = double the period
//  eff    out  PER_W  effective period in clk cycles
module tick_period_calc
  import tick_pkg::*;
#(
  parameter int BASE_PERIOD = 2**24,
  parameter int STEP        = 2**21,
  parameter int MIN_PERIOD  = 2**22
) (
  input  logic [LVL_W-1:0] level,
  input  logic             slow,
  output logic [PER_W-1:0] eff
);

  // Effective period for the requested level and speed mode
  always_comb begin
    eff = period_calc(CALC_W'(BASE_PERIOD), CALC_W'(STEP), CALC_W'(MIN_PERIOD), level, slow);
  end

endmodule

// File: rtl/tick_sched.sv
// Central time base: free-running divider producing scan/debounce enables, plus a
// level-dependent game-tick scheduler sequenced by an IDLE/RUN/PAUSE FSM.
// All outputs are registered single-cycle enables, never derived clocks.
// Optional feature macro: TICK_STEP_EN (single-step game tick from PAUSE on a step rising edge).
// Ports:
//  clk, rst_n   system clock, async active-low reset
//  start        level request IDLE->RUN / PAUSE->RUN
//  pause        request RUN->PAUSE (wins over start)
//  stop         request any state->IDLE (highest priority)
//  slow         double the game period, sampled at reload
//  step         single-step request (TICK_STEP_EN only)
//  scan_tick    display scan enable
//  deb_tick     debounce sample enable
//  game_tick    game advance enable
//  level        current speed level
//  state        00 IDLE, 01 RUN, 10 PAUSE
// The period counter width comes from tick_pkg::PER_W.
module tick_sched
  import tick_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int SCAN_BIT    = 16,
  parameter int DEB_BIT     = 19,
  parameter int BASE_PERIOD = 2**24,
  parameter int STEP        = 2**21,
  parameter int MIN_PERIOD  = 2**22,
  parameter int LEVEL_UP    = 16,
  parameter int MAX_LEVEL   = MAX_LEVEL_CFG
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             pause,
  input  logic             stop,
  input  logic             slow,
  input  logic             step,
  output logic             scan_tick,
  output logic             deb_tick,
  output logic             game_tick,
  output logic [LVL_W-1:0] level,
  output logic [1:0]       state
);

  localparam int TC_W = $clog2(LEVEL_UP) + 1;

  logic [CNT_W-1:0] cnt_r;
  logic             scan_tick_r;
  logic             deb_tick_r;
  logic             game_tick_r;
  state_t           state_r;
  logic [LVL_W-1:0] level_r;
  logic [PER_W-1:0] per_cnt_r;
  logic [TC_W-1:0]  tick_cnt_r;

  logic [LVL_W-1:0] lvl_sel_s;
  logic [PER_W-1:0] eff_s;
  logic [TC_W-1:0]  tc_next_s;
  logic [LVL_W-1:0] lvl_next_s;
  logic             step_rise_s;

  // A start from IDLE restarts at level 0, so the loaded period must ignore the held level.
  assign lvl_sel_s = (state_r == ST_IDLE) ? '0 : level_r;

  tick_period_calc #(
    .BASE_PERIOD (BASE_PERIOD),
    .STEP        (STEP),
    .MIN_PERIOD  (MIN_PERIOD)
  ) u_period_calc (
    .level (lvl_sel_s),
    .slow  (slow),
    .eff   (eff_s)
  );

`ifdef TICK_STEP_EN
  logic step_d_r;

  // Previous step value for rising-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_d_r <= 1'b0;
    end else begin
      step_d_r <= step;
    end
  end

  assign step_rise_s = step & ~step_d_r;
`else
  logic unused_step_s;
  assign unused_step_s = step;
  assign step_rise_s   = 1'b0;
`endif

  // Free-running divider and the two fixed-rate enables (not gated by the FSM)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r       <= '0;
      scan_tick_r <= 1'b0;
      deb_tick_r  <= 1'b0;
    end else begin
      cnt_r       <= cnt_r + CNT_W'(1);
      scan_tick_r <= &cnt_r[SCAN_BIT-1:0];
      deb_tick_r  <= &cnt_r[DEB_BIT-1:0];
    end
  end

  // Tick count and level after one more game tick; level saturates
  always_comb begin
    tc_next_s  = tick_cnt_r + TC_W'(1);
    lvl_next_s = level_r;
    if (tick_cnt_r == TC_W'(LEVEL_UP - 1)) begin
      tc_next_s = '0;
      if (level_r != LVL_W'(MAX_LEVEL)) begin
        lvl_next_s = level_r + LVL_W'(1);
      end else begin
        lvl_next_s = level_r;
      end
    end else begin
      tc_next_s  = tick_cnt_r + TC_W'(1);
      lvl_next_s = level_r;
    end
  end

  // Run/pause/stop FSM with period down-counter, tick count and level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      level_r     <= '0;
      per_cnt_r   <= '0;
      tick_cnt_r  <= '0;
      game_tick_r <= 1'b0;
    end else begin
      game_tick_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          // pause is meaningless here but still blocks a simultaneous start
          if (!stop && !pause && start) begin
            state_r    <= ST_RUN;
            per_cnt_r  <= eff_s - PER_W'(1);
            level_r    <= '0;
            tick_cnt_r <= '0;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_RUN: begin
          // stop/pause take effect on the accepting edge, so a coinciding expiry is dropped
          if (stop) begin
            state_r <= ST_IDLE;
          end else if (pause) begin
            state_r <= ST_PAUSE;
          end else if (per_cnt_r == '0) begin
            game_tick_r <= 1'b1;
            per_cnt_r   <= eff_s - PER_W'(1);
            tick_cnt_r  <= tc_next_s;
            level_r     <= lvl_next_s;
          end else begin
            per_cnt_r <= per_cnt_r - PER_W'(1);
          end
        end
        ST_PAUSE: begin
          if (stop) begin
            state_r <= ST_IDLE;
          end else if (start && !pause) begin
            state_r <= ST_RUN;
          end else if (step_rise_s) begin
            // single step: counter untouched, bookkeeping as for a normal tick
            game_tick_r <= 1'b1;
            tick_cnt_r  <= tc_next_s;
            level_r     <= lvl_next_s;
          end else begin
            state_r <= ST_PAUSE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign scan_tick = scan_tick_r;
  assign deb_tick  = deb_tick_r;
  assign game_tick = game_tick_r;
  assign level     = level_r;
  assign state     = state_r;

endmodule

// File: tb/tb_tick_sched.sv
// Directed bench for tick_sched with small periods:
// BASE_PERIOD=16, STEP=2, MIN_PERIOD=4, LEVEL_UP=4, MAX_LEVEL=7, SCAN_BIT=2, DEB_BIT=3.
module tb_tick_sched;

  logic                      clk;
  logic                      rst_n;
  logic                      start;
  logic                      pause;
  logic                      stop;
  logic                      slow;
  logic                      step;
  logic                      scan_tick;
  logic                      deb_tick;
  logic                      game_tick;
  logic [tick_pkg::LVL_W-1:0] level;
  logic [1:0]                state;

  int n_checks = 0;
  int n_fail   = 0;

  tick_sched #(
    .CNT_W       (32),
    .SCAN_BIT    (2),
    .DEB_BIT     (3),
    .BASE_PERIOD (16),
    .STEP        (2),
    .MIN_PERIOD  (4),
    .LEVEL_UP    (4),
    .MAX_LEVEL   (7)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .pause     (pause),
    .stop      (stop),
    .slow      (slow),
    .step      (step),
    .scan_tick (scan_tick),
    .deb_tick  (deb_tick),
    .game_tick (game_tick),
    .level     (level),
    .state     (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Negedges until game_tick is seen; -1 when the bound expires.
  task automatic wait_tick(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (game_tick !== 1'b1 && cyc < 200);
    if (game_tick !== 1'b1) cyc = -1;
  endtask

  task automatic count_ticks(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (game_tick === 1'b1) cnt++;
    end
  endtask

  function automatic int exp_period(input int lvl, input bit slw);
    int p;
    p = 16 - 2 * lvl;
    if (p < 4) p = 4;
    return slw ? 2 * p : p;
  endfunction

  initial begin
    int cyc;
    int cnt;
    int n_scan;
    int n_deb;
    int n_game;
    int first_scan;
    int lvl_m;
    int tc_m;
    int per_m;
    int nxt;
    int exp_step;

    rst_n = 1'b0; start = 1'b0; pause = 1'b0; stop = 1'b0; slow = 1'b0; step = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_scan", 32'(scan_tick), 32'd0);
    check("rst_deb", 32'(deb_tick), 32'd0);
    check("rst_game", 32'(game_tick), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_state", 32'(state), 32'd0);

    // Divider enables after reset release; FSM stays idle
    rst_n = 1'b1;
    n_scan = 0; n_deb = 0; n_game = 0; first_scan = 0;
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk);
      if (scan_tick === 1'b1) begin
        n_scan++;
        if (first_scan == 0) first_scan = i;
      end
      if (deb_tick === 1'b1) n_deb++;
      if (game_tick === 1'b1) n_game++;
    end
    check("scan_count", 32'(n_scan), 32'd8);
    check("scan_first", 32'(first_scan), 32'd4);
    check("deb_count", 32'(n_deb), 32'd4);
    check("idle_game", 32'(n_game), 32'd0);
    check("idle_state", 32'(state), 32'd0);

    // Start and run through level saturation
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_state", 32'(state), 32'd1);
    lvl_m = 0; tc_m = 0; per_m = 16;
    for (int n = 1; n <= 30; n++) begin
      wait_tick(cyc);
      check("run_interval", 32'(cyc), 32'(per_m));
      nxt = exp_period(lvl_m, 1'b0);
      tc_m++;
      if (tc_m == 4) begin
        tc_m = 0;
        if (lvl_m < 7) lvl_m++;
      end
      per_m = nxt;
      check("run_level", 32'(level), 32'(lvl_m));
    end

    // Slow mode only applies from the next reload
    slow = 1'b1;
    wait_tick(cyc);
    check("slow_cur", 32'(cyc), 32'd4);
    wait_tick(cyc);
    check("slow_next", 32'(cyc), 32'd8);
    slow = 1'b0;
    wait_tick(cyc);
    check("fast_cur", 32'(cyc), 32'd8);
    wait_tick(cyc);
    check("fast_next", 32'(cyc), 32'd4);

    // stop+pause on the expiry edge: idle, tick suppressed, level held
    repeat (3) @(negedge clk);
    stop = 1'b1; pause = 1'b1;
    @(negedge clk);
    stop = 1'b0; pause = 1'b0;
    check("stop_tick", 32'(game_tick), 32'd0);
    check("stop_state", 32'(state), 32'd0);
    check("stop_level", 32'(level), 32'd7);
    count_ticks(20, cnt);
    check("stopped_ticks", 32'(cnt), 32'd0);

    // Restart from level 0
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("restart_state", 32'(state), 32'd1);
    check("restart_level", 32'(level), 32'd0);
    wait_tick(cyc);
    check("restart_period", 32'(cyc), 32'd16);

    // Pause 5 cycles into a period
    repeat (5) @(negedge clk);
    pause = 1'b1;
    @(negedge clk);
    pause = 1'b0;
    check("pause_state", 32'(state), 32'd2);
    count_ticks(20, cnt);
    check("paused_ticks", 32'(cnt), 32'd0);
    start = 1'b1; pause = 1'b1;
    @(negedge clk);
    start = 1'b0; pause = 1'b0;
    check("start_pause_state", 32'(state), 32'd2);

    // Held step gives at most one tick
`ifdef TICK_STEP_EN
    exp_step = 1;
`else
    exp_step = 0;
`endif
    step = 1'b1;
    count_ticks(10, cnt);
    step = 1'b0;
    check("step_ticks", 32'(cnt), 32'(exp_step));
    check("step_state", 32'(state), 32'd2);

    // Resume finishes the remaining 11 cycles
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("resume_state", 32'(state), 32'd1);
    wait_tick(cyc);
    check("resume_remaining", 32'(cyc), 32'd11);
    wait_tick(cyc);
    check("resume_period", 32'(cyc), 32'd16);

    // Async reset while game_tick is high
    #2 rst_n = 1'b0;
    #1;
    check("arst_game", 32'(game_tick), 32'd0);
    check("arst_state", 32'(state), 32'd0);
    check("arst_level", 32'(level), 32'd0);
    check("arst_scan", 32'(scan_tick), 32'd0);
    check("arst_deb", 32'(deb_tick), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
